vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 1024x768@60 VGA raster timing (65 MHz pixel clock): horizontal/vertical counters, sync pulses, and the per-pixel request strobe `VGA_IF_RGBEN` consumed by the display compositor. It samples the compositor's returned `VGA_BUF_RGB` after a fixed, parameterised latency and aligns it with delayed HS/VS/DE, so the DAC/pins see registered, phase-matched sync and pixel data. It sits between the display compositor (pixel source) and the board VGA pins.

## Interface
- P_H_ACT, 1024, visible pixels per line
- P_H_FP, 24, horizontal front porch (clocks)
- P_H_SYNC, 136, horizontal sync width
- P_H_BP, 160, horizontal back porch
- P_V_ACT, 768, visible lines per frame
- P_V_FP, 3, vertical front porch (lines)
- P_V_SYNC, 6, vertical sync width
- P_V_BP, 29, vertical back porch
- P_HS_POL, 0, HS active level (0 = active-low)
- P_VS_POL, 0, VS active level
- P_RGB_LAT, 2, cycles from an `VGA_IF_RGBEN`-high cycle to valid `VGA_BUF_RGB` for that pixel; legal 1..8
- VGA_CLK  in  1  pixel clock; one clock, all logic on rising edge
- RST_N  in  1  reset; synchronous, active-high
- VGA_BUF_RGB  in  24  pixel colour from compositor, {R,G,B}
- VGA_IF_RGBEN  out  1  pixel request; high exactly once per visible pixel, raster order
- VGA_HS  out  1  horizontal sync
- VGA_VS  out  1  vertical sync
- VGA_DE  out  1  data enable, aligned with VGA_RGB
- VGA_RGB  out  24  pixel to pins; 0 when VGA_DE low
- FRAME_START  out  1  one-cycle pulse on first VGA_DE cycle of each frame

## Operation
- H_TOTAL = H_ACT+H_FP+H_SYNC+H_BP (1344); V_TOTAL = V_ACT+V_FP+V_SYNC+V_BP (806). Counters 11 bits, unsigned.
- h_cnt increments every cycle; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt at V_TOTAL-1 with h wrap → 0.
- Visible: h_cnt < H_ACT and v_cnt < V_ACT. HS active: H_ACT+H_FP ≤ h_cnt < H_ACT+H_FP+H_SYNC. VS active: V_ACT+V_FP ≤ v_cnt < V_ACT+V_FP+V_SYNC (whole lines, changes only at h_cnt = 0).
- RGBEN count per frame is exactly H_ACT*V_ACT, so the compositor's X/Y counters stay aligned without a sync input.
- Raw HS/VS/DE/first-pixel flags pass through a delay line of depth P_RGB_LAT+1; VGA_BUF_RGB is registered once, masked to 0 when delayed DE is low.

## Timing
- Reset values: h_cnt=v_cnt=0, VGA_IF_RGBEN=0, VGA_DE=0, VGA_RGB=0, FRAME_START=0, VGA_HS=~P_HS_POL, VGA_VS=~P_VS_POL; delay line cleared to inactive.
- Counters at (h,v) in cycle n → VGA_IF_RGBEN in cycle n+1 (registered compare).
- Pixel requested in cycle m → VGA_BUF_RGB sampled at end of cycle m+P_RGB_LAT → VGA_RGB/DE/HS/VS for that position in cycle m+P_RGB_LAT+1. Total counter-to-pin latency P_RGB_LAT+2.
- First cycle after reset release counters are (0,0); first VGA_IF_RGBEN high in that cycle+1.
- Reset mid-frame: next cycle all outputs at reset values, delay line flushed, counters restart at (0,0); compositor shares RST_N so its X/Y re-align.
- Reset takes priority over wrap; no other inputs affect state.

## Structure
- Package `vga_timing_pkg`: 1024x768 timing constants, counter width (11), RGB width (24), derived H_TOTAL/V_TOTAL functions.
- Sub-module `vga_delay_line`: parameterised depth/width shift register with synchronous reset, used for {FRAME_START, DE, VS, HS}.

## Test plan
- Reset: RST_N high 3 cycles mid-run → all outputs at reset values; release → VGA_IF_RGBEN high 1 cycle after release, 5 consecutive cycles (small config).
- Small config H 5/1/2/2 (total 10), V 4/1/1/1 (total 7): frame = 70 cycles, 20 RGBEN per frame, HS low at h=6..7 each line, VS low for line 5 only.
- Latency: bench model returns pixel index after P_RGB_LAT; VGA_RGB shows 0,1,2… with VGA_DE high, zero elsewhere, for P_RGB_LAT=1, 2, 8; FRAME_START coincides with pixel 0.
- Reset at h=3, v=2 → next cycle reset values; following frame identical to post-power-up frame.
- P_HS_POL=1, P_VS_POL=1 → syncs idle low, pulse high, same positions.
- Default config: HS period 1344, VS period 1344*806 cycles, 786432 RGBEN per frame, HS low 136, VS low 6*1344.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants, widths and helper types for the 1024x768@60 VGA
// raster generator and its delay line.
package vga_timing_pkg;

    localparam int CNT_W = 11;
    localparam int RGB_W = 24;

    localparam int H_ACT  = 1024;
    localparam int H_FP   = 24;
    localparam int H_SYNC = 136;
    localparam int H_BP   = 160;
    localparam int V_ACT  = 768;
    localparam int V_FP   = 3;
    localparam int V_SYNC = 6;
    localparam int V_BP   = 29;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic first;
        logic de;
        logic vs;
        logic hs;
    } sync_flags_t;

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    localparam int H_TOTAL = h_total(H_ACT, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACT, V_FP, V_SYNC, V_BP);

endpackage

// File: rtl/vga_timing_gen_delay_line.sv
// Fixed-depth shift register with synchronous reset to a programmable value;
// carries the sync/enable flags alongside the compositor's pixel latency.
module vga_delay_line #(
    parameter int unsigned          DEPTH   = 1,
    parameter int unsigned          WIDTH   = 1,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] delayed
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: counters, registered pixel request, and pin-side sync/DE/RGB
// phase-aligned to the compositor's fixed return latency.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int P_H_ACT   = H_ACT,
    parameter int P_H_FP    = H_FP,
    parameter int P_H_SYNC  = H_SYNC,
    parameter int P_H_BP    = H_BP,
    parameter int P_V_ACT   = V_ACT,
    parameter int P_V_FP    = V_FP,
    parameter int P_V_SYNC  = V_SYNC,
    parameter int P_V_BP    = V_BP,
    parameter bit P_HS_POL  = 1'b0,
    parameter bit P_VS_POL  = 1'b0,
    parameter int P_RGB_LAT = 2
) (
    input  logic             VGA_CLK,
    input  logic             RST_N,
    input  logic [RGB_W-1:0] VGA_BUF_RGB,
    output logic             VGA_IF_RGBEN,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_DE,
    output logic [RGB_W-1:0] VGA_RGB,
    output logic             FRAME_START
);

    localparam cnt_t H_LAST   = cnt_t'(h_total(P_H_ACT, P_H_FP, P_H_SYNC, P_H_BP) - 1);
    localparam cnt_t V_LAST   = cnt_t'(v_total(P_V_ACT, P_V_FP, P_V_SYNC, P_V_BP) - 1);
    localparam cnt_t H_VIS    = cnt_t'(P_H_ACT);
    localparam cnt_t V_VIS    = cnt_t'(P_V_ACT);
    localparam cnt_t HS_START = cnt_t'(P_H_ACT + P_H_FP);
    localparam cnt_t HS_STOP  = cnt_t'(P_H_ACT + P_H_FP + P_H_SYNC);
    localparam cnt_t VS_START = cnt_t'(P_V_ACT + P_V_FP);
    localparam cnt_t VS_STOP  = cnt_t'(P_V_ACT + P_V_FP + P_V_SYNC);

    localparam sync_flags_t INACTIVE = '{first: 1'b0, de: 1'b0, vs: ~P_VS_POL, hs: ~P_HS_POL};

    cnt_t             h_cnt;
    cnt_t             v_cnt;
    sync_flags_t      raw_next;
    sync_flags_t      raw;
    sync_flags_t      pins;
    logic [RGB_W-1:0] rgb_q;

    always_ff @(posedge VGA_CLK) begin
        if (RST_N) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + cnt_t'(1);
        end else begin
            h_cnt <= h_cnt + cnt_t'(1);
        end
    end

    always_comb begin
        raw_next       = INACTIVE;
        raw_next.de    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        raw_next.first = raw_next.de && (h_cnt == '0) && (v_cnt == '0);
        if ((h_cnt >= HS_START) && (h_cnt < HS_STOP)) begin
            raw_next.hs = P_HS_POL;
        end
        // v_cnt only moves on the h wrap, so VS naturally spans whole lines
        if ((v_cnt >= VS_START) && (v_cnt < VS_STOP)) begin
            raw_next.vs = P_VS_POL;
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (RST_N) begin
            raw <= INACTIVE;
        end else begin
            raw <= raw_next;
        end
    end

    assign VGA_IF_RGBEN = raw.de;

    // The extra stage beyond P_RGB_LAT matches the input register on VGA_BUF_RGB
    vga_delay_line #(
        .DEPTH   (P_RGB_LAT + 1),
        .WIDTH   ($bits(sync_flags_t)),
        .RST_VAL (INACTIVE)
    ) u_flag_delay (
        .clk     (VGA_CLK),
        .rst     (RST_N),
        .data    (raw),
        .delayed (pins)
    );

    always_ff @(posedge VGA_CLK) begin
        if (RST_N) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= VGA_BUF_RGB;
        end
    end

    assign VGA_HS      = pins.hs;
    assign VGA_VS      = pins.vs;
    assign VGA_DE      = pins.de;
    assign FRAME_START = pins.first;
    assign VGA_RGB     = pins.de ? rgb_q : '0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four small-geometry instances (latency 1/2/8, both
// sync polarities) against a queued reference, plus the full 1024x768 timing.
module tb_vga_timing_gen;

    localparam int NS = 4;
    localparam int S_HT = 10;
    localparam int S_VT = 7;
    localparam int S_FRAME_PIX = 20;
    localparam logic [23:0] D_COLOR = 24'hA5C35A;
    localparam int D_HT = 1344;
    localparam int D_LAT = 2;

    function automatic int lat_of(input int g);
        case (g)
            0:       return 1;
            2:       return 8;
            default: return 2;
        endcase
    endfunction

    function automatic bit pol_of(input int g);
        return (g == 3);
    endfunction

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [23:0] rgb;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [NS-1:0]       rgben_s, hs_s, vs_s, de_s, fs_s;
    logic [NS-1:0][23:0] rgb_s, buf_s;

    for (genvar g = 0; g < NS; g++) begin : g_small
        localparam int LAT = lat_of(g);
        logic [23:0] pidx;
        logic [23:0] pipe [8];

        // Compositor stand-in: returns the raster index of each request LAT cycles later
        always @(posedge clk) begin
            if (rst) pidx <= '0;
            else if (rgben_s[g]) pidx <= (pidx == 24'(S_FRAME_PIX - 1)) ? '0 : pidx + 24'd1;
            pipe[0] <= rgben_s[g] ? pidx : 24'hBADBAD;
            for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
        end
        assign buf_s[g] = pipe[LAT-1];

        vga_timing_gen #(
            .P_H_ACT(5), .P_H_FP(1), .P_H_SYNC(2), .P_H_BP(2),
            .P_V_ACT(4), .P_V_FP(1), .P_V_SYNC(1), .P_V_BP(1),
            .P_HS_POL(pol_of(g)), .P_VS_POL(pol_of(g)), .P_RGB_LAT(LAT)
        ) dut (
            .VGA_CLK(clk), .RST_N(rst), .VGA_BUF_RGB(buf_s[g]),
            .VGA_IF_RGBEN(rgben_s[g]), .VGA_HS(hs_s[g]), .VGA_VS(vs_s[g]),
            .VGA_DE(de_s[g]), .VGA_RGB(rgb_s[g]), .FRAME_START(fs_s[g])
        );
    end

    logic        d_rgben, d_hs, d_vs, d_de, d_fs;
    logic [23:0] d_rgb;

    vga_timing_gen #(.P_RGB_LAT(D_LAT)) dut_default (
        .VGA_CLK(clk), .RST_N(rst), .VGA_BUF_RGB(D_COLOR),
        .VGA_IF_RGBEN(d_rgben), .VGA_HS(d_hs), .VGA_VS(d_vs),
        .VGA_DE(d_de), .VGA_RGB(d_rgb), .FRAME_START(d_fs)
    );

    int   total = 0;
    int   bad = 0;
    int   mh, mv, mpix;
    logic prev_vis;
    exp_t q [NS][$];

    function automatic exp_t inactive(input bit pol);
        exp_t e;
        e.hs = ~pol; e.vs = ~pol; e.de = 1'b0; e.fs = 1'b0; e.rgb = '0;
        return e;
    endfunction

    function automatic exp_t small_expect(input int h, input int v, input int pix, input bit pol);
        exp_t e;
        e.de  = (h < 5) && (v < 4);
        e.hs  = (h >= 6 && h < 8) ? pol : ~pol;
        e.vs  = (v == 5) ? pol : ~pol;
        e.fs  = e.de && (h == 0) && (v == 0);
        e.rgb = e.de ? 24'(pix) : 24'd0;
        return e;
    endfunction

    function automatic exp_t dflt_expect(input int k);
        exp_t e;
        int h, v;
        h = k % D_HT;
        v = k / D_HT;
        e.de  = (h < 1024) && (v < 768);
        e.hs  = !(h >= 1048 && h < 1184);
        e.vs  = !(v >= 771 && v < 777);
        e.fs  = e.de && (k == 0);
        e.rgb = e.de ? D_COLOR : 24'd0;
        return e;
    endfunction

    function automatic exp_t small_pins(input int g);
        exp_t a;
        a.hs = hs_s[g]; a.vs = vs_s[g]; a.de = de_s[g]; a.fs = fs_s[g]; a.rgb = rgb_s[g];
        return a;
    endfunction

    task automatic note_fail(input string msg);
        bad++;
        if (bad <= 20) $display("FAIL %s", msg);
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; mpix = 0; prev_vis = 1'b0;
        for (int g = 0; g < NS; g++) begin
            q[g].delete();
            for (int i = 0; i < lat_of(g) + 2; i++) q[g].push_back(inactive(pol_of(g)));
        end
    endtask

    // One cycle at the falling edge: push expectation for current counters, pop the one due at the pins
    task automatic step_small(input string tag);
        exp_t e, a;
        logic vis;
        vis = (mh < 5) && (mv < 4);
        for (int g = 0; g < NS; g++) begin
            q[g].push_back(small_expect(mh, mv, mpix, pol_of(g)));
            e = q[g].pop_front();
            a = small_pins(g);
            total++;
            if (a !== e)
                note_fail($sformatf("%s pins[%0d] at (%0d,%0d) got=%h want=%h", tag, g, mh, mv, a, e));
            total++;
            if (rgben_s[g] !== prev_vis)
                note_fail($sformatf("%s rgben[%0d] at (%0d,%0d) got=%b want=%b", tag, g, mh, mv, rgben_s[g], prev_vis));
        end
        prev_vis = vis;
        if (vis) mpix = (mpix + 1) % S_FRAME_PIX;
        mh++;
        if (mh == S_HT) begin
            mh = 0;
            mv = (mv + 1) % S_VT;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_all(input string tag);
        exp_t a, e;
        for (int g = 0; g < NS; g++) begin
            a = small_pins(g);
            e = inactive(pol_of(g));
            total++;
            if (a !== e || rgben_s[g] !== 1'b0)
                note_fail($sformatf("%s reset[%0d] got=%h/%b want=%h/0", tag, g, a, rgben_s[g], e));
        end
        total++;
        if ({d_hs, d_vs, d_de, d_fs, d_rgben, d_rgb} !== {5'b11000, 24'd0})
            note_fail($sformatf("%s reset_default got=%b%b%b%b%b/%h want=11000/000000",
                                tag, d_hs, d_vs, d_de, d_fs, d_rgben, d_rgb));
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_all("test_reset");
        rst = 1'b0;
        model_reset();
        repeat (6) step_small("test_reset");
    endtask

    task automatic test_frames();
        int ren, hsa, vsa;
        ren = 0; hsa = 0; vsa = 0;
        for (int i = 0; i < S_HT * S_VT; i++) begin
            ren += int'(rgben_s[0]);
            hsa += int'(hs_s[0] == 1'b0);
            vsa += int'(vs_s[0] == 1'b0);
            step_small("test_frames");
        end
        total++;
        if (ren != 20) note_fail($sformatf("frame_rgben got=%0d want=20", ren));
        total++;
        if (hsa != 14) note_fail($sformatf("frame_hs_low got=%0d want=14", hsa));
        total++;
        if (vsa != 10) note_fail($sformatf("frame_vs_low got=%0d want=10", vsa));
        repeat (S_HT * S_VT + 12) step_small("test_frames");
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 80 && !(mh == 3 && mv == 2); i++) step_small("seek");
        total++;
        if (!(mh == 3 && mv == 2)) note_fail($sformatf("mid_reset_seek got=(%0d,%0d) want=(3,2)", mh, mv));
        rst = 1'b1;
        @(negedge clk);
        check_reset_all("test_mid_reset");
        rst = 1'b0;
        model_reset();
        repeat (S_HT * S_VT + 12) step_small("test_mid_reset");
    endtask

    task automatic test_default();
        exp_t dq[$];
        exp_t e, a;
        int   falls[$];
        int   ren, low;
        logic prev_hs;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < D_LAT + 2; i++) dq.push_back(inactive(1'b0));
        ren = 0; low = 0; prev_hs = 1'b1;
        for (int k = 0; k < 3 * D_HT + 8; k++) begin
            dq.push_back(dflt_expect(k));
            e = dq.pop_front();
            a.hs = d_hs; a.vs = d_vs; a.de = d_de; a.fs = d_fs; a.rgb = d_rgb;
            total++;
            if (a !== e) note_fail($sformatf("default_pins k=%0d got=%h want=%h", k, a, e));
            if (k >= 1 && k <= D_HT) ren += int'(d_rgben);
            if (k >= D_LAT + 2 + D_HT && k < D_LAT + 2 + 2 * D_HT) low += int'(d_hs == 1'b0);
            if (prev_hs && !d_hs) falls.push_back(k);
            prev_hs = d_hs;
            @(negedge clk);
        end
        total++;
        if (ren != 1024) note_fail($sformatf("default_rgben_line got=%0d want=1024", ren));
        total++;
        if (low != 136) note_fail($sformatf("default_hs_low got=%0d want=136", low));
        total++;
        if (falls.size() < 3) begin
            note_fail($sformatf("default_hs_falls got=%0d want>=3", falls.size()));
        end else if (falls[0] != 1048 + D_LAT + 2 || falls[1] - falls[0] != D_HT || falls[2] - falls[1] != D_HT) begin
            note_fail($sformatf("default_hs_period got=%0d,%0d,%0d want=%0d,+1344,+1344",
                                falls[0], falls[1], falls[2], 1048 + D_LAT + 2));
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_frames();
        test_mid_reset();
        test_default();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
